// File: rtl/i2c_byte_sequencer.sv
// ---------------------------------------------------------------------------
// i2c_byte_sequencer
//
// Byte-level command sequencer for the APB I2C master. Breaks a decoded
// command (start / read / write / stop) into single-bit operations for the
// SCL/SDA bit controller, and returns the received byte, the slave ACK and
// a one-cycle completion pulse to the register block.
//
// Ports
//   HCLK, HRESETn        clock, asynchronous active-low reset
//   ena_i                core enable; low forces IDLE
//   start_i .. write_i   command bits from the register block
//   ack_in_i             ACK bit to send after a read (0 = ACK)
//   din_i                byte to transmit, MSB first
//   cmd_ack_o            one-cycle pulse, command sequence complete
//   ack_out_o            ACK bit sampled in the last ACK slot
//   dout_o               received byte (shift register)
//   i2c_al_o             one-cycle pulse, arbitration lost
//   bit_cmd_o/bit_txd_o  bit command and SDA value to the bit controller
//   bit_ack_i/bit_rxd_i  bit command done / sampled SDA
//   bit_al_i             arbitration lost from the bit controller
//
// state   | meaning
// --------+---------------------------------------------------
// S_IDLE  | waiting for a command
// S_START | (repeated) START issued to the bit controller
// S_WRITE | shifting out a data bit
// S_READ  | shifting in a data bit
// S_ACK   | ACK slot (read ACK after write, drive ACK after read)
// S_STOP  | STOP issued to the bit controller
// ---------------------------------------------------------------------------
module i2c_byte_sequencer (
  input  logic       HCLK,
  input  logic       HRESETn,
  input  logic       ena_i,
  input  logic       start_i,
  input  logic       stop_i,
  input  logic       read_i,
  input  logic       write_i,
  input  logic       ack_in_i,
  input  logic [7:0] din_i,
  output logic       cmd_ack_o,
  output logic       ack_out_o,
  output logic [7:0] dout_o,
  output logic       i2c_al_o,
  output logic [2:0] bit_cmd_o,
  output logic       bit_txd_o,
  input  logic       bit_ack_i,
  input  logic       bit_rxd_i,
  input  logic       bit_al_i
);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_WRITE, S_READ, S_ACK, S_STOP
  } state_t;

  localparam logic [2:0] CMD_NOP   = 3'd0;
  localparam logic [2:0] CMD_START = 3'd1;
  localparam logic [2:0] CMD_STOP  = 3'd2;
  localparam logic [2:0] CMD_WRITE = 3'd3;
  localparam logic [2:0] CMD_READ  = 3'd4;

  state_t     state_q,   state_d;
  logic [2:0] cnt_q,     cnt_d;
  logic [7:0] sr_q,      sr_d;
  logic [2:0] bit_cmd_q, bit_cmd_d;
  logic       bit_txd_q, bit_txd_d;
  logic       cmd_ack_q, cmd_ack_d;
  logic       ack_out_q, ack_out_d;
  logic       al_q,      al_d;
  logic       go;

  // Command bits stay high for one cycle after done; masking with the
  // done pulse keeps them from restarting the sequence.
  assign go = (start_i | stop_i | read_i | write_i) & ~cmd_ack_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sr_d      = sr_q;
    bit_cmd_d = bit_cmd_q;
    bit_txd_d = bit_txd_q;
    ack_out_d = ack_out_q;
    cmd_ack_d = 1'b0;
    al_d      = 1'b0;

    if (bit_al_i) begin
      // Arbitration loss beats a simultaneous bit_ack_i; sr/cnt frozen.
      state_d   = S_IDLE;
      bit_cmd_d = CMD_NOP;
      al_d      = 1'b1;
    end else if (!ena_i) begin
      state_d   = S_IDLE;
      bit_cmd_d = CMD_NOP;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (go) begin
            sr_d  = din_i;
            cnt_d = 3'd7;
            if (start_i) begin
              state_d   = S_START;
              bit_cmd_d = CMD_START;
            end else if (read_i) begin
              state_d   = S_READ;
              bit_cmd_d = CMD_READ;
            end else if (write_i) begin
              state_d   = S_WRITE;
              bit_cmd_d = CMD_WRITE;
              bit_txd_d = din_i[7];
            end else begin
              state_d   = S_STOP;
              bit_cmd_d = CMD_STOP;
            end
          end
        end
        S_START: begin
          if (bit_ack_i) begin
            if (read_i) begin
              state_d   = S_READ;
              bit_cmd_d = CMD_READ;
            end else if (write_i) begin
              state_d   = S_WRITE;
              bit_cmd_d = CMD_WRITE;
              bit_txd_d = sr_q[7];
            end else if (stop_i) begin
              state_d   = S_STOP;
              bit_cmd_d = CMD_STOP;
            end else begin
              state_d   = S_IDLE;
              bit_cmd_d = CMD_NOP;
              cmd_ack_d = 1'b1;
            end
          end
        end
        S_WRITE, S_READ: begin
          if (bit_ack_i) begin
            sr_d = {sr_q[6:0], bit_rxd_i};
            if (cnt_q != 3'd0) begin
              cnt_d = cnt_q - 3'd1;
              if (state_q == S_WRITE) bit_txd_d = sr_q[6];
            end else begin
              state_d = S_ACK;
              if (state_q == S_WRITE) begin
                bit_cmd_d = CMD_READ;
              end else begin
                bit_cmd_d = CMD_WRITE;
                bit_txd_d = ack_in_i;
              end
            end
          end
        end
        S_ACK: begin
          if (bit_ack_i) begin
            ack_out_d = bit_rxd_i;
            if (stop_i) begin
              state_d   = S_STOP;
              bit_cmd_d = CMD_STOP;
            end else begin
              state_d   = S_IDLE;
              bit_cmd_d = CMD_NOP;
              cmd_ack_d = 1'b1;
            end
          end
        end
        S_STOP: begin
          if (bit_ack_i) begin
            state_d   = S_IDLE;
            bit_cmd_d = CMD_NOP;
            cmd_ack_d = 1'b1;
          end
        end
        default: begin
          state_d   = S_IDLE;
          bit_cmd_d = CMD_NOP;
        end
      endcase
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q   <= S_IDLE;
      cnt_q     <= 3'd0;
      sr_q      <= 8'h00;
      bit_cmd_q <= CMD_NOP;
      bit_txd_q <= 1'b0;
      cmd_ack_q <= 1'b0;
      ack_out_q <= 1'b0;
      al_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sr_q      <= sr_d;
      bit_cmd_q <= bit_cmd_d;
      bit_txd_q <= bit_txd_d;
      cmd_ack_q <= cmd_ack_d;
      ack_out_q <= ack_out_d;
      al_q      <= al_d;
    end
  end

  assign cmd_ack_o = cmd_ack_q;
  assign ack_out_o = ack_out_q;
  assign dout_o    = sr_q;
  assign i2c_al_o  = al_q;
  assign bit_cmd_o = bit_cmd_q;
  assign bit_txd_o = bit_txd_q;

endmodule

// File: tb/tb_i2c_byte_sequencer.sv
module tb_i2c_byte_sequencer;

  localparam logic [2:0] C_NOP   = 3'd0;
  localparam logic [2:0] C_START = 3'd1;
  localparam logic [2:0] C_STOP  = 3'd2;
  localparam logic [2:0] C_WRITE = 3'd3;
  localparam logic [2:0] C_READ  = 3'd4;

  logic       HCLK;
  logic       HRESETn;
  logic       ena_i, start_i, stop_i, read_i, write_i, ack_in_i;
  logic [7:0] din_i;
  logic       cmd_ack_o, ack_out_o, i2c_al_o, bit_txd_o;
  logic [7:0] dout_o;
  logic [2:0] bit_cmd_o;
  logic       bit_ack_i, bit_rxd_i, bit_al_i;

  int n_cmp;
  int n_bad;

  i2c_byte_sequencer dut (
    .HCLK      (HCLK),
    .HRESETn   (HRESETn),
    .ena_i     (ena_i),
    .start_i   (start_i),
    .stop_i    (stop_i),
    .read_i    (read_i),
    .write_i   (write_i),
    .ack_in_i  (ack_in_i),
    .din_i     (din_i),
    .cmd_ack_o (cmd_ack_o),
    .ack_out_o (ack_out_o),
    .dout_o    (dout_o),
    .i2c_al_o  (i2c_al_o),
    .bit_cmd_o (bit_cmd_o),
    .bit_txd_o (bit_txd_o),
    .bit_ack_i (bit_ack_i),
    .bit_rxd_i (bit_rxd_i),
    .bit_al_i  (bit_al_i)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check_val({tag, " bit_cmd"}, 32'(bit_cmd_o), 32'(C_NOP));
    check_val({tag, " bit_txd"}, 32'(bit_txd_o), 32'd0);
    check_val({tag, " cmd_ack"}, 32'(cmd_ack_o), 32'd0);
    check_val({tag, " ack_out"}, 32'(ack_out_o), 32'd0);
    check_val({tag, " dout"},    32'(dout_o),    32'h00);
    check_val({tag, " al"},      32'(i2c_al_o),  32'd0);
  endtask

  task automatic set_cmds(input logic s, input logic p, input logic r, input logic w);
    start_i = s; stop_i = p; read_i = r; write_i = w;
  endtask

  // Bit controller ack: one cycle pulse, called and returning at a negedge.
  task automatic ack_bit(input logic rxd);
    bit_rxd_i = rxd;
    bit_ack_i = 1'b1;
    @(negedge HCLK);
    bit_ack_i = 1'b0;
  endtask

  // Runs one command end to end. The expected bit-command list is built here
  // from the command flags; data/ack results are hand-computed by the caller.
  task automatic run_seq(input string tag, input logic s, input logic p, input logic r,
                         input logic w, input logic ackin, input logic [7:0] din,
                         input logic [7:0] rxbyte, input logic ackbit, input int dly,
                         input logic [7:0] exp_dout, input logic exp_ack);
    logic [2:0] ecmd[$];
    logic       etv[$];
    logic       etx[$];
    logic       erx[$];
    logic       rd, wr;
    rd = r;
    wr = w & ~r;
    if (s) begin ecmd.push_back(C_START); etv.push_back(1'b0); etx.push_back(1'b0); erx.push_back(1'b0); end
    if (rd | wr) begin
      for (int k = 7; k >= 0; k--) begin
        ecmd.push_back(wr ? C_WRITE : C_READ);
        etv.push_back(wr);
        etx.push_back(din[k]);
        erx.push_back(rxbyte[k]);
      end
      ecmd.push_back(wr ? C_READ : C_WRITE);
      etv.push_back(rd);
      etx.push_back(ackin);
      erx.push_back(ackbit);
    end
    if (p || !(s | rd | wr)) begin
      ecmd.push_back(C_STOP); etv.push_back(1'b0); etx.push_back(1'b0); erx.push_back(1'b0);
    end

    set_cmds(s, p, r, w);
    ack_in_i = ackin;
    din_i = din;
    @(negedge HCLK);
    for (int i = 0; i < ecmd.size(); i++) begin
      for (int d = 0; d < dly; d++) begin
        check_val($sformatf("%s hold%0d", tag, i), 32'(bit_cmd_o), 32'(ecmd[i]));
        @(negedge HCLK);
      end
      check_val($sformatf("%s cmd%0d", tag, i), 32'(bit_cmd_o), 32'(ecmd[i]));
      if (etv[i]) check_val($sformatf("%s txd%0d", tag, i), 32'(bit_txd_o), 32'(etx[i]));
      check_val($sformatf("%s early_ack%0d", tag, i), 32'(cmd_ack_o), 32'd0);
      ack_bit(erx[i]);
    end
    check_val({tag, " done"}, 32'(cmd_ack_o), 32'd1);
    check_val({tag, " done_cmd"}, 32'(bit_cmd_o), 32'(C_NOP));
    check_val({tag, " dout"}, 32'(dout_o), 32'(exp_dout));
    check_val({tag, " ack_out"}, 32'(ack_out_o), 32'(exp_ack));
    // Command bits still held for one cycle after done: no retrigger.
    @(negedge HCLK);
    check_val({tag, " done_1cyc"}, 32'(cmd_ack_o), 32'd0);
    check_val({tag, " no_retrig"}, 32'(bit_cmd_o), 32'(C_NOP));
    set_cmds(1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge HCLK);
    check_val({tag, " idle_after"}, 32'(bit_cmd_o), 32'(C_NOP));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp = 0;
    n_bad = 0;
    HRESETn = 1'b0;
    ena_i = 1'b1;
    set_cmds(1'b0, 1'b0, 1'b0, 1'b0);
    ack_in_i = 1'b0;
    din_i = 8'h00;
    bit_ack_i = 1'b0;
    bit_rxd_i = 1'b0;
    bit_al_i = 1'b0;
    repeat (2) @(negedge HCLK);
    check_reset_vals("reset");
    HRESETn = 1'b1;
    @(negedge HCLK);

    // start+write 0xA5, slave ACKs (0); SDA readback equals txd.
    run_seq("wr_a5", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'hA5, 8'hA5, 1'b0, 0, 8'hA5, 1'b0);

    // read+stop, NACK sent, received 0x3C.
    run_seq("rd_3c", 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h00, 8'h3C, 1'b1, 0, 8'h3C, 1'b1);

    // stop only, slow bit controller; sr and ack_out untouched except the load.
    run_seq("stop", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h3C, 8'h00, 1'b0, 2, 8'h3C, 1'b1);

    // Arbitration lost on the 3rd WRITE ack (bit_ack in the same cycle).
    set_cmds(1'b1, 1'b0, 1'b0, 1'b1);
    din_i = 8'hFF;
    @(negedge HCLK);
    ack_bit(1'b0);
    ack_bit(1'b0);
    ack_bit(1'b0);
    check_val("al pre_cmd", 32'(bit_cmd_o), 32'(C_WRITE));
    bit_al_i = 1'b1;
    ack_bit(1'b0);
    bit_al_i = 1'b0;
    check_val("al cmd", 32'(bit_cmd_o), 32'(C_NOP));
    check_val("al pulse", 32'(i2c_al_o), 32'd1);
    check_val("al no_done", 32'(cmd_ack_o), 32'd0);
    check_val("al dout_frozen", 32'(dout_o), 32'hFC);
    set_cmds(1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge HCLK);
    check_val("al pulse_1cyc", 32'(i2c_al_o), 32'd0);
    check_val("al no_done2", 32'(cmd_ack_o), 32'd0);
    check_val("al idle", 32'(bit_cmd_o), 32'(C_NOP));

    // Reset asserted during the 5th READ bit.
    set_cmds(1'b1, 1'b0, 1'b1, 1'b0);
    din_i = 8'h00;
    @(negedge HCLK);
    ack_bit(1'b0);
    for (int k = 0; k < 4; k++) ack_bit(1'b1);
    check_val("rst pre_cmd", 32'(bit_cmd_o), 32'(C_READ));
    check_val("rst pre_dout", 32'(dout_o), 32'h0F);
    #2;
    HRESETn = 1'b0;
    #1;
    check_reset_vals("rst async");
    set_cmds(1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge HCLK);
    check_reset_vals("rst held");
    HRESETn = 1'b1;
    @(negedge HCLK);
    run_seq("wr_01", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h01, 8'h01, 1'b0, 0, 8'h01, 1'b0);

    // ena_i dropped after three WRITE bits of 0x5A.
    set_cmds(1'b0, 1'b0, 1'b0, 1'b1);
    din_i = 8'h5A;
    @(negedge HCLK);
    for (int k = 0; k < 3; k++) ack_bit(1'b0);
    check_val("ena pre_cmd", 32'(bit_cmd_o), 32'(C_WRITE));
    ena_i = 1'b0;
    @(negedge HCLK);
    check_val("ena cmd", 32'(bit_cmd_o), 32'(C_NOP));
    check_val("ena no_done", 32'(cmd_ack_o), 32'd0);
    check_val("ena sr_kept", 32'(dout_o), 32'hD0);
    @(negedge HCLK);
    check_val("ena no_done2", 32'(cmd_ack_o), 32'd0);
    check_val("ena idle", 32'(bit_cmd_o), 32'(C_NOP));
    set_cmds(1'b0, 1'b0, 1'b0, 1'b0);
    ena_i = 1'b1;
    @(negedge HCLK);
    run_seq("wr_80", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h80, 8'h80, 1'b1, 0, 8'h80, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
